// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets an icache and a dcache share one burst memory port.
// One transaction is in flight at a time: grant in IDLE, address phase, then read beats or a write response.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int IC_LEN = 4,
  parameter int DC_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ic_req,
  input  logic [ADDR_W-1:0]   ic_addr,
  output logic                ic_ready,
  output logic                ic_rvalid,
  output logic [DATA_W-1:0]   ic_rdata,
  output logic                ic_rlast,
  input  logic                dc_req,
  input  logic                dc_wen,
  input  logic [ADDR_W-1:0]   dc_addr,
  input  logic [DATA_W-1:0]   dc_wdata,
  input  logic [DATA_W/8-1:0] dc_wstrb,
  output logic                dc_ready,
  output logic                dc_rvalid,
  output logic [DATA_W-1:0]   dc_rdata,
  output logic                dc_rlast,
  output logic                dc_bdone,
  output logic                mem_req,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [7:0]          mem_len,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rlast,
  input  logic                mem_bvalid
);

  typedef enum logic [1:0] {IDLE, REQ, RDATA, WRESP} state_t;
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_owner;
  logic                  r_last_grant;
  logic                  r_wen;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic [7:0]            r_len;
  logic                  w_idle;
  logic                  w_grant_ic;
  logic                  w_grant_dc;

  // Grants are suppressed while rst is high so a waiting request is only taken after reset releases.
  assign w_idle     = (r_state == IDLE) && !rst;
  assign w_grant_ic = w_idle && ic_req && (!dc_req || (r_last_grant == OWN_DC));
  assign w_grant_dc = w_idle && dc_req && !w_grant_ic;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= OWN_IC;
      r_last_grant <= OWN_DC;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_len        <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_ic || w_grant_dc) begin
        r_owner      <= w_grant_dc ? OWN_DC : OWN_IC;
        r_last_grant <= w_grant_dc ? OWN_DC : OWN_IC;
        r_addr       <= w_grant_dc ? dc_addr : ic_addr;
        r_wen        <= w_grant_dc && dc_wen;
        r_wdata      <= w_grant_dc ? dc_wdata : '0;
        r_wstrb      <= w_grant_dc ? dc_wstrb : '0;
        if (w_grant_ic)
          r_len <= 8'(IC_LEN - 1);
        else if (dc_wen)
          r_len <= 8'd0;
        else
          r_len <= 8'(DC_LEN - 1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    ic_ready     = 1'b0;
    dc_ready     = 1'b0;
    ic_rvalid    = 1'b0;
    ic_rlast     = 1'b0;
    dc_rvalid    = 1'b0;
    dc_rlast     = 1'b0;
    dc_bdone     = 1'b0;
    mem_req      = 1'b0;
    mem_wen      = 1'b0;
    case (r_state)
      IDLE: begin
        ic_ready = w_grant_ic;
        dc_ready = w_grant_dc;
        if (w_grant_ic || w_grant_dc)
          w_state_next = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        mem_wen = r_wen;
        if (mem_ready)
          w_state_next = r_wen ? WRESP : RDATA;
      end
      RDATA: begin
        // Only valid/last are steered; data is broadcast to both caches.
        ic_rvalid = mem_rvalid && (r_owner == OWN_IC);
        ic_rlast  = mem_rvalid && mem_rlast && (r_owner == OWN_IC);
        dc_rvalid = mem_rvalid && (r_owner == OWN_DC);
        dc_rlast  = mem_rvalid && mem_rlast && (r_owner == OWN_DC);
        if (mem_rvalid && mem_rlast)
          w_state_next = IDLE;
      end
      WRESP: begin
        dc_bdone = mem_bvalid;
        if (mem_bvalid)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign mem_len   = r_len;
  assign ic_rdata  = mem_rdata;
  assign dc_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter; a transaction-level model predicts
// the round-robin winner, latched fields and beat routing.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int IC_LEN = 4;
  localparam int DC_LEN = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ic_req;
  logic [31:0]       ic_addr;
  logic              ic_ready, ic_rvalid, ic_rlast;
  logic [63:0]       ic_rdata;
  logic              dc_req, dc_wen;
  logic [31:0]       dc_addr;
  logic [63:0]       dc_wdata;
  logic [7:0]        dc_wstrb;
  logic              dc_ready, dc_rvalid, dc_rlast, dc_bdone;
  logic [63:0]       dc_rdata;
  logic              mem_req, mem_wen;
  logic [31:0]       mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wstrb;
  logic [7:0]        mem_len;
  logic              mem_ready, mem_rvalid, mem_rlast, mem_bvalid;
  logic [63:0]       mem_rdata;

  int n_pass  = 0;
  int n_total = 0;
  bit m_last_dc;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IC_LEN(IC_LEN), .DC_LEN(DC_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_rlast(ic_rlast),
    .dc_req(dc_req), .dc_wen(dc_wen), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wstrb(dc_wstrb), .dc_ready(dc_ready), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .dc_rlast(dc_rlast), .dc_bdone(dc_bdone),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_len(mem_len), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rlast(mem_rlast), .mem_bvalid(mem_bvalid)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Starts in an IDLE cycle, drives the requests, and follows the whole transaction back to IDLE.
  task automatic run_txn(input bit ic_r, input bit dc_r, input bit wen,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [63:0] wd, input logic [7:0] ws,
                         input int rdly, input int bdly);
    bit          any, win_dc, ewen;
    logic [31:0] eaddr;
    logic [7:0]  elen;
    logic [63:0] rd;
    int          b, beats;
    ic_req = ic_r; dc_req = dc_r; dc_wen = wen;
    ic_addr = ia; dc_addr = da; dc_wdata = wd; dc_wstrb = ws;
    mem_ready = 1'b0;
    mem_rvalid = 1'($urandom); mem_rlast = mem_rvalid; mem_bvalid = 1'($urandom);
    #1;
    any    = ic_r || dc_r;
    win_dc = (ic_r && dc_r) ? !m_last_dc : dc_r;
    chk("ic_ready", ic_ready, any && !win_dc);
    chk("dc_ready", dc_ready, any && win_dc);
    chk("idle_mem_req", mem_req, 1'b0);
    chk("idle_stray_rvalid", {ic_rvalid, dc_rvalid, dc_bdone}, 3'b000);
    if (!any) begin
      cyc();
      mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_bvalid = 1'b0;
      return;
    end
    m_last_dc = win_dc;
    eaddr = win_dc ? da : ia;
    ewen  = win_dc && wen;
    elen  = !win_dc ? 8'(IC_LEN - 1) : (wen ? 8'd0 : 8'(DC_LEN - 1));
    cyc();
    mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_bvalid = 1'b0;
    if (win_dc) dc_req = 1'($urandom); else ic_req = 1'($urandom);
    ic_addr = $urandom; dc_addr = $urandom; dc_wdata = {$urandom, $urandom};
    for (int d = 0; d <= rdly; d++) begin
      mem_ready = (d == rdly);
      #1;
      chk("mem_req", mem_req, 1'b1);
      chk("mem_addr", mem_addr, eaddr);
      chk("mem_len", mem_len, elen);
      chk("mem_wen", mem_wen, ewen);
      if (ewen) begin
        chk("mem_wdata", mem_wdata, wd);
        chk("mem_wstrb", mem_wstrb, ws);
      end
      chk("busy_ready", {ic_ready, dc_ready}, 2'b00);
      cyc();
    end
    mem_ready = 1'b0;
    if (!ewen) begin
      b = 0;
      beats = int'(elen) + 1;
      while (b < beats) begin
        rd = {$urandom, $urandom};
        mem_rdata = rd;
        if ($urandom_range(0, 3) == 0) begin
          mem_rvalid = 1'b0; mem_rlast = 1'($urandom); mem_bvalid = 1'b1;
          #1;
          chk("gap_flags", {ic_rvalid, dc_rvalid, ic_rlast, dc_rlast, dc_bdone}, 5'b00000);
          chk("gap_rdata", ic_rdata, rd);
        end else begin
          mem_rvalid = 1'b1; mem_rlast = (b == beats - 1); mem_bvalid = 1'b0;
          #1;
          chk("ic_rvalid", ic_rvalid, !win_dc);
          chk("dc_rvalid", dc_rvalid, win_dc);
          chk("ic_rlast", ic_rlast, !win_dc && (b == beats - 1));
          chk("dc_rlast", dc_rlast, win_dc && (b == beats - 1));
          chk("rdata", win_dc ? dc_rdata : ic_rdata, rd);
          b++;
        end
        cyc();
      end
    end else begin
      for (int d = 0; d <= bdly; d++) begin
        mem_bvalid = (d == bdly);
        mem_rvalid = 1'($urandom); mem_rlast = mem_rvalid;
        #1;
        chk("dc_bdone", dc_bdone, d == bdly);
        chk("wresp_rvalid", {ic_rvalid, dc_rvalid}, 2'b00);
        cyc();
      end
    end
    mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_bvalid = 1'b0;
    $display("txn owner=%s wen=%0d addr=0x%08h len=%0d", win_dc ? "dc" : "ic", ewen, eaddr, elen);
  endtask

  initial begin
    rst = 1'b1;
    ic_req = 1'b1; dc_req = 1'b1; dc_wen = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; dc_wstrb = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_bvalid = 1'b0; mem_rdata = '0;

    // Reset held with both requests pending.
    repeat (3) cyc();
    #1;
    chk("rst_ready", {ic_ready, dc_ready}, 2'b00);
    chk("rst_mem_req", {mem_req, mem_wen}, 2'b00);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_flags", {ic_rvalid, ic_rlast, dc_rvalid, dc_rlast, dc_bdone}, 5'b00000);
    cyc();
    rst = 1'b0;
    m_last_dc = 1'b1;

    // Three simultaneous contests: ic, dc, ic.
    run_txn(1, 1, 0, 32'h1000_0000, 32'h2000_0000, 64'h0, 8'h0, 1, 0);
    run_txn(1, 1, 0, 32'h1000_0040, 32'h2000_0040, 64'h0, 8'h0, 0, 0);
    run_txn(1, 1, 0, 32'h1000_0080, 32'h2000_0080, 64'h0, 8'h0, 2, 0);
    // Single icache miss and dcache write with a stalled address phase.
    run_txn(1, 0, 0, 32'h8000_0000, 32'h0, 64'h0, 8'h0, 0, 0);
    run_txn(0, 1, 1, 32'h0, 32'h8000_1000, 64'h1122_3344_5566_7788, 8'hFF, 3, 2);
    run_txn(0, 0, 0, 32'h0, 32'h0, 64'h0, 8'h0, 0, 0);

    // Reset pulse during beat 2 of an icache burst with a dcache request waiting.
    ic_req = 1'b1; dc_req = 1'b0; ic_addr = 32'h9000_0000;
    #1;
    chk("rb_ic_ready", ic_ready, 1'b1);
    cyc();
    ic_req = 1'b0; mem_ready = 1'b1;
    #1;
    chk("rb_mem_req", mem_req, 1'b1);
    cyc();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rlast = 1'b0; mem_rdata = 64'hA5A5_0001_A5A5_0001;
    #1;
    chk("rb_beat1", ic_rvalid, 1'b1);
    cyc();
    rst = 1'b1; dc_req = 1'b1; dc_wen = 1'b0; mem_rdata = 64'hA5A5_0002_A5A5_0002;
    #1;
    chk("rb_rst_dc_ready", dc_ready, 1'b0);
    cyc();
    rst = 1'b0;
    m_last_dc = 1'b1;
    run_txn(0, 1, 0, 32'h0, 32'h9000_1000, 64'h0, 8'h0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
              {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 64, data beat width.
REQ-003 SHALL have parameter IC_LEN, default 4, icache read burst beats.
REQ-004 SHALL have parameter DC_LEN, default 4, dcache read burst beats.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports ic_req in 1 (icache miss request) and ic_addr in ADDR_W (line address).
REQ-008 SHALL have ports ic_ready out 1, ic_rvalid out 1, ic_rdata out DATA_W, ic_rlast out 1: grant handshake and returned beats.
REQ-009 SHALL have ports dc_req in 1, dc_wen in 1 (1 = single-beat write), dc_addr in ADDR_W, dc_wdata in DATA_W, dc_wstrb in DATA_W/8.
REQ-010 SHALL have ports dc_ready out 1, dc_rvalid out 1, dc_rdata out DATA_W, dc_rlast out 1, dc_bdone out 1 (write complete).
REQ-011 SHALL have ports mem_req out 1, mem_wen out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_wstrb out DATA_W/8, mem_len out 8 (beats-1).
REQ-012 SHALL have ports mem_ready in 1, mem_rvalid in 1, mem_rdata in DATA_W, mem_rlast in 1, mem_bvalid in 1.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, RDATA, WRESP; reset state IDLE.
REQ-014 In IDLE, a request is accepted in the same cycle: the winner's xx_ready is driven high combinationally for exactly that cycle; the loser's ready stays low.
REQ-015 Arbitration SHALL be round-robin: with both requests high, the winner is the requester not granted last; with one request, that requester wins.
REQ-016 A last_grant register SHALL update on each accepted request; its reset value SHALL be dcache, so icache wins the first simultaneous contest.
REQ-017 On acceptance, owner, address, wen, wdata, wstrb and len (IC_LEN-1, DC_LEN-1, or 0 for writes) SHALL be latched; FSM moves to REQ next cycle.
REQ-018 In REQ, mem_req=1 with latched fields stable until mem_ready=1; then go to RDATA (read) or WRESP (write).
REQ-019 In RDATA, mem_rvalid/mem_rdata/mem_rlast SHALL be forwarded combinationally to the owner only; the non-owner's rvalid/rlast stay 0.
REQ-020 RDATA exits to IDLE in the cycle after mem_rvalid&&mem_rlast; the next grant is possible in the following IDLE cycle (one idle cycle minimum between transactions).
REQ-021 In WRESP, mem_bvalid=1 SHALL produce a one-cycle dc_bdone=1 in the same cycle, then go to IDLE.
REQ-022 mem_rvalid outside RDATA, and mem_bvalid outside WRESP, SHALL be ignored with no output effect.
REQ-023 No preemption: requests arriving while not IDLE are held off (ready low) until IDLE.
REQ-024 A requester dropping xx_req after acceptance SHALL NOT abort the transaction.
REQ-025 mem_wen SHALL be 1 only for dcache writes; icache transactions always read.
REQ-026 xx_rdata SHALL equal mem_rdata at all times; only valid and last flags are gated.

Reset
REQ-027 Reset SHALL put FSM in IDLE and clear mem_req, mem_wen, all ready, rvalid, rlast and bdone outputs to 0; latched address and data registers cleared to 0.
REQ-028 Reset asserted mid-transaction SHALL abandon it; beats or responses returning after reset are ignored per REQ-022.
REQ-029 A request present during reset SHALL NOT be granted until the first cycle after rst deasserts.

Verification
REQ-030 Single icache miss: ic_req=1, ic_addr=0x80000000 in IDLE -> ic_ready=1 same cycle; next cycle mem_req=1, addr 0x80000000, len=3, wen=0; 4 beats forwarded, ic_rlast on beat 4; IDLE after.
REQ-031 Simultaneous ic_req and dc_req right after reset -> icache granted first; dcache granted in the first IDLE cycle after icache rlast; a third contest goes to icache again.
REQ-032 dcache write: dc_wen=1, dc_addr=0x80001000, wdata=0x1122334455667788, wstrb=0xFF -> mem_wen=1, len=0, fields held while mem_ready=0 for 3 cycles; mem_bvalid -> dc_bdone pulse of 1 cycle.
REQ-033 Stray mem_rvalid in IDLE and stray mem_bvalid during RDATA -> no rvalid or bdone on either requester.
REQ-034 rst pulsed during beat 2 of an icache burst -> all outputs 0 next cycle; remaining beats ignored; a pending dc_req is granted in the first cycle after rst deasserts.
